// File: rtl/mygo_chan_pkg.sv
// mygo_chan_pkg: shared constants and helpers for the channel write arbiter
package mygo_chan_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_WRITERS = 16;
  localparam int CNT_W = 32;
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/mygo_rr_pick.sv
// mygo_rr_pick: combinational first-set search starting at a rotating pointer
module mygo_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign rot = N'({req_i, req_i} >> ptr_i);
  always_comb begin
    found_o = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        found_o = 1'b1;
        off = IW'(k);
      end
  end
  assign sum = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
  assign onehot_o = found_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/mygo_chan_write_arb.sv
// mygo_chan_write_arb: round-robin N-to-1 arbiter feeding one channel FIFO,
// holding the grant through a stall so a pending element is never swapped out.
module mygo_chan_write_arb
  import mygo_chan_pkg::*;
#(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WRITERS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WRITERS-1:0]            wr_valid,
  output logic [NUM_WRITERS-1:0]            wr_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_WRITERS-1:0]            grant,
  output logic [CNT_W-1:0]                  xfer_count
);
  localparam int IW = NUM_WRITERS > 1 ? $clog2(NUM_WRITERS) : 1;
  logic [IW-1:0] prio_ptr_q, prio_ptr_d, lock_idx_q, lock_idx_d;
  logic lock_q, lock_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
  logic [NUM_WRITERS-1:0] pick_oh, sel_oh;
  logic [IW-1:0] pick_idx, sel_idx;
  logic pick_found, sel_v, xfer;
  mygo_rr_pick #(.N(NUM_WRITERS), .IW(IW)) u_pick (
    .req_i(wr_valid),
    .ptr_i(prio_ptr_q),
    .onehot_o(pick_oh),
    .idx_o(pick_idx),
    .found_o(pick_found)
  );
  assign sel_idx = lock_q ? lock_idx_q : pick_idx;
  assign sel_oh = lock_q ? NUM_WRITERS'(1) << lock_idx_q : pick_oh;
  assign sel_v = lock_q ? wr_valid[lock_idx_q] : pick_found;
  assign out_valid = !rst && sel_v;
  assign grant = rst ? '0 : sel_oh;
  assign out_data = wr_data[int'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign xfer = out_valid && out_ready;
  assign wr_ready = {NUM_WRITERS{xfer}} & sel_oh & wr_valid;
  assign xfer_count = xfer_count_q;
  always_comb begin
    prio_ptr_d = prio_ptr_q;
    lock_d = lock_q;
    lock_idx_d = lock_idx_q;
    xfer_count_d = xfer_count_q;
    if (xfer) begin
      lock_d = 1'b0;
      prio_ptr_d = IW'(wrap_inc(32'(sel_idx), NUM_WRITERS));
      xfer_count_d = xfer_count_q + 1'b1;
    end else if (sel_v) begin
      lock_d = 1'b1;
      lock_idx_d = sel_idx;
    end else begin
      lock_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      xfer_count_q <= '0;
    end else begin
      prio_ptr_q <= prio_ptr_d;
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      xfer_count_q <= xfer_count_d;
    end
  end
endmodule

// File: tb/tb_mygo_chan_write_arb.sv
// tb_mygo_chan_write_arb: randomized and directed checks against a behavioural arbiter model
module tb_mygo_chan_write_arb;
  localparam int N = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0] wr_valid = '0;
  logic [N-1:0] wr_ready;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [N-1:0] grant;
  logic [31:0] xfer_count;
  int n_chk = 0;
  int n_bad = 0;
  int m_ptr = 0;
  int m_lidx = 0;
  bit m_lock = 0;
  logic [31:0] m_cnt = '0;
  logic [N-1:0] last_grant;
  logic [DW-1:0] last_data;
  mygo_chan_write_arb #(.NUM_WRITERS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant(grant),
    .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction
  task automatic cycle(input logic [N-1:0] v, input logic r, input logic rs, input logic [N*DW-1:0] d);
    int gi;
    logic ev;
    logic [N-1:0] eg, er;
    wr_valid = v;
    out_ready = r;
    rst = rs;
    wr_data = d;
    gi = m_lock ? m_lidx : pick(v, m_ptr);
    ev = !rs && gi >= 0 && v[gi];
    eg = (rs || gi < 0) ? '0 : N'(1) << gi;
    er = (ev && r) ? eg : '0;
    #1;
    last_grant = grant;
    last_data = out_data;
    chk("grant", grant, eg);
    chk("out_valid", out_valid, ev);
    chk("wr_ready", wr_ready, er);
    chk("xfer_count", xfer_count, m_cnt);
    if (ev) chk("out_data", out_data, d[gi*DW +: DW]);
    @(posedge clk);
    if (rs) begin
      m_ptr = 0;
      m_lock = 0;
      m_lidx = 0;
      m_cnt = '0;
    end else if (ev && r) begin
      m_lock = 0;
      m_ptr = (gi + 1) % N;
      m_cnt++;
    end else if (ev) begin
      m_lock = 1;
      m_lidx = gi;
    end else m_lock = 0;
    @(negedge clk);
  endtask
  initial begin
    logic [N*DW-1:0] fixed;
    @(negedge clk);
    cycle(4'b1111, 1'b1, 1'b1, rnd_data());
    chk("rst_ready", wr_ready, '0);
    cycle(4'b0000, 1'b1, 1'b1, rnd_data());
    fixed = '0;
    fixed[DW-1:0] = 32'h4;
    cycle(4'b0001, 1'b1, 1'b0, fixed);
    chk("single_data", last_data, 32'h4);
    cycle(4'b0000, 1'b1, 1'b0, fixed);
    chk("single_cnt", xfer_count, 32'd1);
    cycle(4'b0000, 1'b0, 1'b1, fixed);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, 1'b0, rnd_data());
      chk("rotate", last_grant, 4'b0001 << (i % 4));
    end
    chk("rotate_cnt", xfer_count, 32'd8);
    cycle(4'b0000, 1'b0, 1'b1, fixed);
    cycle(4'b0001, 1'b1, 1'b0, fixed);
    cycle(4'b0010, 1'b1, 1'b0, fixed);
    fixed = rnd_data();
    cycle(4'b0100, 1'b0, 1'b0, fixed);
    for (int i = 0; i < 2; i++) begin
      cycle(4'b0101, 1'b0, 1'b0, fixed);
      chk("stall_grant", last_grant, 4'b0100);
      chk("stall_data", last_data, fixed[2*DW +: DW]);
    end
    cycle(4'b0101, 1'b1, 1'b0, fixed);
    chk("stall_xfer", last_grant, 4'b0100);
    cycle(4'b0101, 1'b1, 1'b0, fixed);
    chk("after_stall", last_grant, 4'b0001);
    cycle(4'b0000, 1'b0, 1'b1, fixed);
    cycle(4'b0010, 1'b0, 1'b0, fixed);
    cycle(4'b0001, 1'b0, 1'b0, fixed);
    cycle(4'b0101, 1'b1, 1'b0, fixed);
    chk("drop_rearb", last_grant, 4'b0001);
    cycle(4'b0000, 1'b0, 1'b1, fixed);
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 1'b0, rnd_data());
    cycle(4'b1111, 1'b0, 1'b0, fixed);
    cycle(4'b1111, 1'b1, 1'b1, fixed);
    chk("rst_mid_valid", out_valid, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, fixed);
    chk("rst_first", last_grant, 4'b0001);
    force dut.xfer_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_count_q;
    m_cnt = 32'hFFFF_FFFF;
    cycle(4'b0010, 1'b1, 1'b0, rnd_data());
    chk("wrap", xfer_count, 32'd0);
    for (int i = 0; i < 400; i++)
      cycle(N'($urandom), ($urandom % 4) != 0, ($urandom % 60) == 0, rnd_data());
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
